spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning the transfer word width in bits (legal range 8..32).
REQ-002 The block SHALL have parameter CLK_DIV, default 4, meaning the SCLK half-period in clk_i cycles (legal range 1..255).
REQ-003 Port clk_i  in  1  system clock; all logic SHALL run on the rising edge.
REQ-004 Port rst_ni  in  1  reset, asynchronous and active-low.
REQ-005 Port start_i  in  1  transfer request, sampled in IDLE only.
REQ-006 Port tx_data_i  in  N  word to send, MSB first, captured on the accepting edge.
REQ-007 Port busy_o  out  1  high from the accepting edge until done_o asserts.
REQ-008 Port done_o  out  1  one-cycle pulse at transfer completion.
REQ-009 Port rx_data_o  out  N  last received word, updated only with done_o.
REQ-010 Port spi_sclk_o  out  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-011 Port spi_cs_o  out  1  chip select, active-low.
REQ-012 Port spi_mosi_o  out  1  master out, slave in.
REQ-013 Port spi_miso_i  in  1  master in, slave out; the block SHALL assume it is already synchronous to clk_i.

Function
REQ-014 The block SHALL use states IDLE, LEAD, HIGH, LOW and TRAIL. A divider counter SHALL reload to 0 on every state change, and a "tick" SHALL occur when the counter equals CLK_DIV-1.
REQ-015 In IDLE with start_i=1, the next edge SHALL: load the tx shift register with tx_data_i, set busy_o=1, spi_cs_o=0 and spi_mosi_o=tx_data_i[N-1], clear the bit counter, and move to LEAD.
REQ-016 In LEAD, on tick, the block SHALL set spi_sclk_o=1, shift spi_miso_i into the rx shift register LSB, and move to HIGH.
REQ-017 In HIGH, on tick, the block SHALL set spi_sclk_o=0. If the bit counter equals N-1 it SHALL move to TRAIL. Otherwise it SHALL shift the tx register left, drive the next bit on spi_mosi_o, increment the bit counter, and move to LOW.
REQ-018 In LOW, on tick, the block SHALL set spi_sclk_o=1, sample spi_miso_i into the rx register, and move to HIGH.
REQ-019 In TRAIL, on tick, the block SHALL in the same edge: set spi_cs_o=1, copy the rx register to rx_data_o, pulse done_o=1, set busy_o=0, and move to IDLE.
REQ-020 spi_cs_o SHALL stay low for exactly (2N+1)*CLK_DIV cycles; spi_sclk_o SHALL give exactly N rising edges while spi_cs_o is low.
REQ-021 spi_mosi_o SHALL change only on a spi_sclk_o falling edge or on the accepting edge, never on a rising edge.
REQ-022 start_i SHALL be ignored while busy_o=1; no queuing.
REQ-023 A start_i asserted in the done_o cycle SHALL be accepted, giving a spi_cs_o high gap of exactly 1 cycle.
REQ-024 In IDLE, spi_sclk_o=0, spi_mosi_o=0 and spi_cs_o=1.

Reset
REQ-025 While rst_ni=0 the block SHALL immediately force: state=IDLE, spi_cs_o=1, spi_sclk_o=0, spi_mosi_o=0, busy_o=0, done_o=0, rx_data_o=0, and shift registers and counters to 0.
REQ-026 A reset during a transfer SHALL abort it: no done_o pulse and no rx_data_o update. The first start_i after release SHALL begin a clean transfer.

Verification
REQ-027 N=32, CLK_DIV=2, tx=0xA5A50F0F, slave model returns 0x12345678 -> MOSI bits decode to 0xA5A50F0F, spi_cs_o low 130 cycles, 32 SCLK rising edges, rx_data_o=0x12345678 with one done_o pulse.
REQ-028 CLK_DIV=1, spi_mosi_o looped to spi_miso_i, tx=0xDEADBEEF -> rx_data_o=0xDEADBEEF, spi_cs_o low 65 cycles.
REQ-029 start_i held high continuously, tx=0xFFFFFFFF then 0x00000000 -> two transfers, spi_cs_o high exactly 1 cycle between them, rx matches the slave model each time.
REQ-030 start_i pulsed mid-transfer with tx=0x11111111 -> ignored; the current word is unaffected; exactly one done_o pulse.
REQ-031 rst_ni driven low at bit 10 of a transfer -> spi_cs_o=1 and spi_sclk_o=0 asynchronously, no done_o pulse, rx_data_o=0; the next transfer of 0x0F0F0F0F completes correctly.
REQ-032 Checker throughout all scenarios: spi_mosi_o is stable on every spi_sclk_o rising edge, and busy_o equals the inverse of spi_cs_o except on the accepting edge.

Source files
------------

// File: rtl/spi_master.sv
// SPI mode-0 master: shifts one N-bit word out on MOSI (MSB first) while capturing MISO.
// SCLK half-period is CLK_DIV system clocks; chip select spans the whole word plus lead/trail.
module spi_master #(
   parameter int N       = 32,
   parameter int CLK_DIV = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         start_i,
   input  logic [N-1:0] tx_data_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [N-1:0] rx_data_o,
   output logic         spi_sclk_o,
   output logic         spi_cs_o,
   output logic         spi_mosi_o,
   input  logic         spi_miso_i,
   output logic [2:0]   dbg_state_o
);

   // Handshake: start_i is a request and ~busy_o is ready. A request is taken on
   // a rising edge where start_i=1 in IDLE; requests while busy are dropped, never queued.

   localparam int BIT_W = $clog2(N);
   localparam int DIV_W = 8;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(N - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LEAD  = 3'd1,
      HIGH  = 3'd2,
      LOW   = 3'd3,
      TRAIL = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   div_cnt_q;
   logic [BIT_W-1:0]   bit_cnt_q;
   logic [N-1:0]       tx_sr_q;
   logic [N-1:0]       rx_sr_q;
   logic               tick;

   assign tick        = (div_cnt_q == DIV_LAST);
   assign dbg_state_o = state_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i) state_d = LEAD;
         LEAD:    if (tick)    state_d = HIGH;
         HIGH:    if (tick)    state_d = (bit_cnt_q == LAST_BIT) ? TRAIL : LOW;
         LOW:     if (tick)    state_d = HIGH;
         TRAIL:   if (tick)    state_d = IDLE;
         default:              state_d = IDLE;
      endcase
   end

   // Divider restarts on every state change so each phase lasts exactly CLK_DIV cycles.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                                 div_cnt_q <= '0;
      else if (state_d != state_q || state_q == IDLE) div_cnt_q <= '0;
      else                                         div_cnt_q <= div_cnt_q + DIV_W'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bit_cnt_q  <= '0;
         tx_sr_q    <= '0;
         rx_sr_q    <= '0;
         rx_data_o  <= '0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         spi_sclk_o <= 1'b0;
         spi_cs_o   <= 1'b1;
         spi_mosi_o <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  tx_sr_q    <= tx_data_i;
                  busy_o     <= 1'b1;
                  spi_cs_o   <= 1'b0;
                  spi_mosi_o <= tx_data_i[N-1];
                  bit_cnt_q  <= '0;
               end
            end
            LEAD, LOW: begin
               if (tick) begin
                  spi_sclk_o <= 1'b1;
                  rx_sr_q    <= {rx_sr_q[N-2:0], spi_miso_i};
               end
            end
            HIGH: begin
               if (tick) begin
                  spi_sclk_o <= 1'b0;
                  // MOSI returns to 0 on the final falling edge so IDLE is entered clean.
                  if (bit_cnt_q == LAST_BIT) begin
                     spi_mosi_o <= 1'b0;
                  end else begin
                     tx_sr_q    <= tx_sr_q << 1;
                     spi_mosi_o <= tx_sr_q[N-2];
                     bit_cnt_q  <= bit_cnt_q + BIT_W'(1);
                  end
               end
            end
            TRAIL: begin
               if (tick) begin
                  spi_cs_o  <= 1'b1;
                  rx_data_o <= rx_sr_q;
                  done_o    <= 1'b1;
                  busy_o    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a mode-0 slave model feeds MISO, monitors decode the bus,
// and each scenario task compares against words and timings derived from the protocol rules.
module tb_spi_master;

   localparam int N      = 32;
   localparam int DIV    = 2;
   localparam int LOW_N  = (2 * N + 1) * DIV;
   localparam int LOW_F  = (2 * N + 1) * 1;

   logic         clk_i = 1'b0;
   logic         rst_ni = 1'b0;
   logic         start_i = 1'b0;
   logic [N-1:0] tx_data_i = '0;
   logic         busy_o, done_o, spi_sclk_o, spi_cs_o, spi_mosi_o, spi_miso_i;
   logic [N-1:0] rx_data_o;
   logic [2:0]   dbg_state_o;

   logic         f_start = 1'b0;
   logic [N-1:0] f_tx = '0;
   logic         f_busy, f_done, f_sclk, f_cs, f_mosi;
   logic [N-1:0] f_rx;
   logic [2:0]   f_state;

   int n_cmp = 0;
   int n_err = 0;
   logic [N-1:0] exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk_i = ~clk_i;

   spi_master #(.N(N), .CLK_DIV(DIV)) u_dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .tx_data_i(tx_data_i),
      .busy_o(busy_o), .done_o(done_o), .rx_data_o(rx_data_o),
      .spi_sclk_o(spi_sclk_o), .spi_cs_o(spi_cs_o), .spi_mosi_o(spi_mosi_o),
      .spi_miso_i(spi_miso_i), .dbg_state_o(dbg_state_o)
   );

   // Second instance at the fastest divider with MOSI looped back to MISO.
   spi_master #(.N(N), .CLK_DIV(1)) u_dut_fast (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(f_start), .tx_data_i(f_tx),
      .busy_o(f_busy), .done_o(f_done), .rx_data_o(f_rx),
      .spi_sclk_o(f_sclk), .spi_cs_o(f_cs), .spi_mosi_o(f_mosi),
      .spi_miso_i(f_mosi), .dbg_state_o(f_state)
   );

   // ---------------- slave model ----------------
   logic [N-1:0] slv_word = '0;
   int           slv_fall = 0;

   always @(posedge spi_cs_o or negedge spi_sclk_o) begin
      if (spi_cs_o !== 1'b0) slv_fall = 0;
      else                   slv_fall = slv_fall + 1;
   end

   always_comb begin
      spi_miso_i = 1'b0;
      if (slv_fall < N) spi_miso_i = slv_word[N-1-slv_fall];
   end

   // ---------------- bus monitors ----------------
   logic         mosi_prev = 1'b0;
   int           viol = 0, stab_viol = 0;
   int           done_cnt = 0, cur_low = 0, last_low = 0, cur_high = 0, last_high = 0;
   int           f_done_cnt = 0, f_cur_low = 0, f_last_low = 0;
   int           rises = 0, last_rises = 0;
   logic [N-1:0] mosi_cap = '0, last_mosi = '0;

   always @(negedge clk_i) begin
      mosi_prev = spi_mosi_o;
      if (busy_o === spi_cs_o) viol = viol + 1;
      if (done_o === 1'b1) done_cnt = done_cnt + 1;
      if (spi_cs_o === 1'b0) cur_low = cur_low + 1;
      else begin
         if (cur_low != 0) last_low = cur_low;
         cur_low = 0;
      end
      if (spi_cs_o === 1'b1) cur_high = cur_high + 1;
      else begin
         if (cur_high != 0) last_high = cur_high;
         cur_high = 0;
      end
      if (f_done === 1'b1) f_done_cnt = f_done_cnt + 1;
      if (f_cs === 1'b0) f_cur_low = f_cur_low + 1;
      else begin
         if (f_cur_low != 0) f_last_low = f_cur_low;
         f_cur_low = 0;
      end
   end

   always @(posedge spi_sclk_o or posedge spi_cs_o) begin
      if (spi_cs_o === 1'b1) begin
         last_rises = rises;
         last_mosi  = mosi_cap;
         rises      = 0;
      end else begin
         rises    = rises + 1;
         mosi_cap = {mosi_cap[N-2:0], spi_mosi_o};
         if (spi_mosi_o !== mosi_prev) stab_viol = stab_viol + 1;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(negedge clk_i);
      #1;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (done_o === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic send(input logic [N-1:0] tx, input logic [N-1:0] slv);
      slv_word  = slv;
      tx_data_i = tx;
      start_i   = 1'b1;
      step();
      start_i   = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_ni = 1'b0;
      repeat (3) step();
      n_cmp++; if (spi_cs_o !== 1'b1) begin n_err++; $display("FAIL reset_cs: got %b want 1", spi_cs_o); end
      n_cmp++; if (spi_sclk_o !== 1'b0) begin n_err++; $display("FAIL reset_sclk: got %b want 0", spi_sclk_o); end
      n_cmp++; if (spi_mosi_o !== 1'b0) begin n_err++; $display("FAIL reset_mosi: got %b want 0", spi_mosi_o); end
      n_cmp++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin n_err++; $display("FAIL reset_busy_done: got %b%b want 00", busy_o, done_o); end
      n_cmp++; if (rx_data_o !== '0) begin n_err++; $display("FAIL reset_rx: got %h want 0", rx_data_o); end
      n_cmp++; if (dbg_state_o !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", dbg_state_o); end
      n_cmp++; if (f_cs !== 1'b1 || f_sclk !== 1'b0 || f_rx !== '0) begin n_err++; $display("FAIL reset_fast: got cs=%b sclk=%b rx=%h", f_cs, f_sclk, f_rx); end
      rst_ni = 1'b1;
      repeat (2) step();
      n_cmp++; if (busy_o !== 1'b0 || spi_cs_o !== 1'b1) begin n_err++; $display("FAIL idle_after_reset: got busy=%b cs=%b want 0/1", busy_o, spi_cs_o); end
   endtask

   task automatic test_transfer(input logic [N-1:0] tx, input logic [N-1:0] slv);
      bit ok;
      int d0;
      logic [N-1:0] exp;
      d0 = done_cnt;
      exp_q.push_back(slv);
      send(tx, slv);
      n_cmp++; if (busy_o !== 1'b1 || spi_cs_o !== 1'b0 || spi_mosi_o !== tx[N-1]) begin
         n_err++; $display("FAIL accept: got busy=%b cs=%b mosi=%b want 1/0/%b", busy_o, spi_cs_o, spi_mosi_o, tx[N-1]); end
      wait_done(4 * LOW_N, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL done_timeout: got no done want done tx=%h", tx); end
      exp = exp_q.pop_front();
      n_cmp++; if (rx_data_o !== exp) begin n_err++; $display("FAIL rx_word: got %h want %h", rx_data_o, exp); end
      n_cmp++; if (last_mosi !== tx) begin n_err++; $display("FAIL mosi_word: got %h want %h", last_mosi, tx); end
      n_cmp++; if (last_low != LOW_N) begin n_err++; $display("FAIL cs_low_len: got %0d want %0d", last_low, LOW_N); end
      n_cmp++; if (last_rises != N) begin n_err++; $display("FAIL sclk_rises: got %0d want %0d", last_rises, N); end
      n_cmp++; if (busy_o !== 1'b0 || spi_mosi_o !== 1'b0 || spi_sclk_o !== 1'b0) begin
         n_err++; $display("FAIL done_idle: got busy=%b mosi=%b sclk=%b want 000", busy_o, spi_mosi_o, spi_sclk_o); end
      step();
      n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL done_pulse_width: got %b want 0", done_o); end
      n_cmp++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL done_count: got %0d want 1", done_cnt - d0); end
   endtask

   task automatic test_basic();
      test_transfer(32'hA5A50F0F, 32'h12345678);
   endtask

   task automatic test_random();
      for (int i = 0; i < 4; i++) test_transfer($urandom, $urandom);
   endtask

   task automatic test_loopback();
      logic [N-1:0] words [2];
      bit ok;
      words[0] = 32'hDEADBEEF;
      words[1] = $urandom;
      for (int w = 0; w < 2; w++) begin
         f_tx    = words[w];
         f_start = 1'b1;
         step();
         f_start = 1'b0;
         ok = 1'b0;
         for (int i = 0; i < 4 * LOW_F; i++) begin
            step();
            if (f_done === 1'b1) begin ok = 1'b1; break; end
         end
         n_cmp++; if (!ok) begin n_err++; $display("FAIL loop_timeout: got no done want done"); end
         n_cmp++; if (f_rx !== words[w]) begin n_err++; $display("FAIL loop_rx: got %h want %h", f_rx, words[w]); end
         n_cmp++; if (f_last_low != LOW_F) begin n_err++; $display("FAIL loop_cs_low: got %0d want %0d", f_last_low, LOW_F); end
         step();
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int d0;
      logic [N-1:0] w1, w2;
      d0 = done_cnt;
      w1 = $urandom;
      w2 = $urandom;
      slv_word  = w1;
      tx_data_i = 32'hFFFFFFFF;
      start_i   = 1'b1;
      step();
      tx_data_i = 32'h00000000;
      wait_done(4 * LOW_N, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_timeout1: got no done want done"); end
      n_cmp++; if (rx_data_o !== w1) begin n_err++; $display("FAIL b2b_rx1: got %h want %h", rx_data_o, w1); end
      n_cmp++; if (last_mosi !== 32'hFFFFFFFF) begin n_err++; $display("FAIL b2b_mosi1: got %h want ffffffff", last_mosi); end
      slv_word = w2;
      step();
      n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL b2b_accept: got busy=%b want 1", busy_o); end
      n_cmp++; if (last_high != 1) begin n_err++; $display("FAIL b2b_cs_gap: got %0d want 1", last_high); end
      wait_done(4 * LOW_N, ok);
      start_i = 1'b0;
      n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_timeout2: got no done want done"); end
      n_cmp++; if (rx_data_o !== w2) begin n_err++; $display("FAIL b2b_rx2: got %h want %h", rx_data_o, w2); end
      n_cmp++; if (last_mosi !== 32'h00000000) begin n_err++; $display("FAIL b2b_mosi2: got %h want 00000000", last_mosi); end
      n_cmp++; if (last_low != LOW_N) begin n_err++; $display("FAIL b2b_cs_low: got %0d want %0d", last_low, LOW_N); end
      repeat (4) step();
      n_cmp++; if (done_cnt - d0 != 2 || busy_o !== 1'b0) begin n_err++; $display("FAIL b2b_count: got %0d busy=%b want 2 busy=0", done_cnt - d0, busy_o); end
   endtask

   task automatic test_ignore_start();
      bit ok;
      int d0;
      logic [N-1:0] a, s;
      d0 = done_cnt;
      a  = $urandom;
      s  = $urandom;
      send(a, s);
      repeat (20) step();
      tx_data_i = 32'h11111111;
      start_i   = 1'b1;
      step();
      start_i   = 1'b0;
      tx_data_i = '0;
      wait_done(4 * LOW_N, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL ign_timeout: got no done want done"); end
      n_cmp++; if (last_mosi !== a) begin n_err++; $display("FAIL ign_mosi: got %h want %h", last_mosi, a); end
      n_cmp++; if (rx_data_o !== s) begin n_err++; $display("FAIL ign_rx: got %h want %h", rx_data_o, s); end
      repeat (LOW_N + 10) step();
      n_cmp++; if (done_cnt - d0 != 1 || busy_o !== 1'b0) begin n_err++; $display("FAIL ign_count: got %0d busy=%b want 1 busy=0", done_cnt - d0, busy_o); end
   endtask

   task automatic test_reset_abort();
      bit reached;
      int d0;
      d0 = done_cnt;
      send($urandom, $urandom);
      reached = 1'b0;
      for (int i = 0; i < 4 * LOW_N; i++) begin
         if (rises >= 10) begin reached = 1'b1; break; end
         step();
      end
      n_cmp++; if (!reached) begin n_err++; $display("FAIL abort_bit10: got rises=%0d want 10", rises); end
      #2 rst_ni = 1'b0;
      #1;
      n_cmp++; if (spi_cs_o !== 1'b1 || spi_sclk_o !== 1'b0 || spi_mosi_o !== 1'b0) begin
         n_err++; $display("FAIL abort_async: got cs=%b sclk=%b mosi=%b want 100", spi_cs_o, spi_sclk_o, spi_mosi_o); end
      n_cmp++; if (busy_o !== 1'b0 || rx_data_o !== '0) begin n_err++; $display("FAIL abort_regs: got busy=%b rx=%h want 0/0", busy_o, rx_data_o); end
      repeat (3) step();
      rst_ni = 1'b1;
      repeat (LOW_N + 20) step();
      n_cmp++; if (done_cnt - d0 != 0 || rx_data_o !== '0) begin n_err++; $display("FAIL abort_nodone: got done=%0d rx=%h want 0/0", done_cnt - d0, rx_data_o); end
      test_transfer(32'h0F0F0F0F, $urandom);
   endtask

   task automatic test_monitors();
      n_cmp++; if (stab_viol != 0) begin n_err++; $display("FAIL mosi_stable: got %0d violations want 0", stab_viol); end
      n_cmp++; if (viol != 0) begin n_err++; $display("FAIL busy_vs_cs: got %0d violations want 0", viol); end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_basic();
      test_random();
      test_loopback();
      test_back_to_back();
      test_ignore_start();
      test_reset_abort();
      test_monitors();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
